// File: rtl/ahb_lite_burst_master_if.sv
// AHB-Lite bus bundle between the burst master and the interconnect.
interface ahb_lite_burst_master_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) ();
   logic                  HREADY;
   logic                  HRESP;
   logic [ADDR_WIDTH-1:0] HADDR;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic [2:0]            HBURST;
   logic [1:0]            HTRANS;
   logic [DATA_WIDTH-1:0] HWDATA;

   modport master (
      input  HREADY, HRESP,
      output HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA
   );

   modport slave (
      output HREADY, HRESP,
      input  HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA
   );
endinterface

// File: rtl/ahb_lite_burst_master.sv
// AHB-Lite write master: sends one NUM_WORDS block as a single incrementing burst.
module ahb_lite_burst_master #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned NUM_WORDS  = 4
) (
   input  logic                            HCLK,
   input  logic                            HRESETn,
   ahb_lite_burst_master_if.master         bus,
   input  logic [ADDR_WIDTH-1:0]           destination,
   input  logic                            dest_updated,
   input  logic [NUM_WORDS*DATA_WIDTH-1:0] encr_text,
   input  logic                            text_rcvd,
   output logic                            busy,
   output logic                            done,
   output logic                            error
);
   localparam int unsigned BYTES  = DATA_WIDTH / 8;
   localparam int unsigned BEAT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [2:0]  SIZE   = 3'($clog2(BYTES));
   localparam logic [2:0]  BURST_FIX = (NUM_WORDS == 4)  ? 3'b011 :
                                       (NUM_WORDS == 8)  ? 3'b101 :
                                       (NUM_WORDS == 16) ? 3'b111 : 3'b001;
   localparam logic [2:0]  BURST_INCR = 3'b001;
   localparam logic [10:0] BLK_BYTES  = 11'(NUM_WORDS * BYTES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BYTES);
   localparam logic [1:0]  HT_IDLE   = 2'b00;
   localparam logic [1:0]  HT_NONSEQ = 2'b10;
   localparam logic [1:0]  HT_SEQ    = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR} state_t;
   typedef logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] text_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
   logic [1:0]            htrans_q, htrans_d;
   logic [2:0]            hburst_q, hburst_d;
   logic [2:0]            hsize_q, hsize_d;
   logic                  hwrite_q, hwrite_d;
   logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   text_t                 buf_q, buf_d;
   logic [ADDR_WIDTH-1:0] dest_q, dest_d;
   logic [ADDR_WIDTH-1:0] pend_q, pend_d;
   logic                  pend_vld_q, pend_vld_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  burst_end;

   logic [ADDR_WIDTH-1:0] dest_in;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic                  cross_1k;

   // Word-aligned capture, start address (same-cycle update wins) and 1 KB crossing test
   assign dest_in    = destination & ALIGN_MASK;
   assign start_addr = dest_updated ? dest_in : dest_q;
   assign next_addr  = haddr_q + ADDR_STEP;
   assign cross_1k   = ({1'b0, start_addr[9:0]} + BLK_BYTES) > 11'd1024;

   // Next-state and registered-output computation
   always_comb begin
      state_d    = state_q;
      haddr_d    = haddr_q;
      htrans_d   = htrans_q;
      hburst_d   = hburst_q;
      hsize_d    = hsize_q;
      hwrite_d   = hwrite_q;
      hwdata_d   = hwdata_q;
      beat_d     = beat_q;
      buf_d      = buf_q;
      dest_d     = dest_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      burst_end  = 1'b0;

      if (dest_updated) begin
         if (state_q == S_IDLE) begin
            dest_d = dest_in;
         end else begin
            pend_d     = dest_in;
            pend_vld_d = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (text_rcvd) begin
               state_d  = S_ADDR;
               buf_d    = encr_text;
               dest_d   = start_addr;
               haddr_d  = start_addr;
               htrans_d = HT_NONSEQ;
               hburst_d = cross_1k ? BURST_INCR : BURST_FIX;
               hsize_d  = SIZE;
               hwrite_d = 1'b1;
               hwdata_d = '0;
               beat_d   = '0;
               busy_d   = 1'b1;
            end
         end
         S_ADDR: begin
            if (bus.HREADY) begin
               hwdata_d = buf_q[0];
               if (NUM_WORDS == 1) begin
                  state_d  = S_LAST;
                  htrans_d = HT_IDLE;
               end else begin
                  state_d  = S_BURST;
                  beat_d   = BEAT_W'(1);
                  haddr_d  = next_addr;
                  htrans_d = (next_addr[9:0] == 10'd0) ? HT_NONSEQ : HT_SEQ;
               end
            end
         end
         S_BURST: begin
            if (bus.HRESP && !bus.HREADY) begin
               state_d  = S_ERR;
               htrans_d = HT_IDLE;
            end else if (bus.HREADY) begin
               hwdata_d = buf_q[beat_q];
               if (beat_q == BEAT_W'(NUM_WORDS - 1)) begin
                  state_d  = S_LAST;
                  htrans_d = HT_IDLE;
               end else begin
                  beat_d   = beat_q + BEAT_W'(1);
                  haddr_d  = next_addr;
                  htrans_d = (next_addr[9:0] == 10'd0) ? HT_NONSEQ : HT_SEQ;
               end
            end
         end
         S_LAST: begin
            if (bus.HREADY) begin
               burst_end = 1'b1;
               done_d    = !bus.HRESP;
               error_d   = bus.HRESP;
            end else if (bus.HRESP) begin
               state_d = S_ERR;
            end
         end
         S_ERR: begin
            if (bus.HREADY) begin
               burst_end = 1'b1;
               error_d   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Burst teardown: bus back to zero, pending destination promoted
      if (burst_end) begin
         state_d    = S_IDLE;
         haddr_d    = '0;
         htrans_d   = HT_IDLE;
         hburst_d   = '0;
         hsize_d    = '0;
         hwrite_d   = 1'b0;
         hwdata_d   = '0;
         busy_d     = 1'b0;
         dest_d     = dest_updated ? dest_in : (pend_vld_q ? pend_q : dest_q);
         pend_vld_d = 1'b0;
      end
   end

   // State and output registers
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= S_IDLE;
         haddr_q    <= '0;
         htrans_q   <= HT_IDLE;
         hburst_q   <= '0;
         hsize_q    <= '0;
         hwrite_q   <= 1'b0;
         hwdata_q   <= '0;
         beat_q     <= '0;
         buf_q      <= '0;
         dest_q     <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         haddr_q    <= haddr_d;
         htrans_q   <= htrans_d;
         hburst_q   <= hburst_d;
         hsize_q    <= hsize_d;
         hwrite_q   <= hwrite_d;
         hwdata_q   <= hwdata_d;
         beat_q     <= beat_d;
         buf_q      <= buf_d;
         dest_q     <= dest_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign bus.HADDR  = haddr_q;
   assign bus.HTRANS = htrans_q;
   assign bus.HBURST = hburst_q;
   assign bus.HSIZE  = hsize_q;
   assign bus.HWRITE = hwrite_q;
   assign bus.HWDATA = hwdata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
endmodule

// File: tb/tb_ahb_lite_burst_master.sv
// Scoreboard bench for ahb_lite_burst_master (32-bit bus, 4-word blocks).
module tb_ahb_lite_burst_master;
   logic         HCLK;
   logic         HRESETn;
   logic [31:0]  destination;
   logic         dest_updated;
   logic [127:0] encr_text;
   logic         text_rcvd;
   logic         busy, done, error;

   ahb_lite_burst_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

   ahb_lite_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_WORDS(4)) dut (
      .HCLK         (HCLK),
      .HRESETn      (HRESETn),
      .bus          (bus),
      .destination  (destination),
      .dest_updated (dest_updated),
      .encr_text    (encr_text),
      .text_rcvd    (text_rcvd),
      .busy         (busy),
      .done         (done),
      .error        (error)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  trans;
      logic [2:0]  burst;
   } beat_t;

   beat_t       exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   logic [1:0]  exp_cmp_q[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   bit          data_pend = 1'b0;

   localparam logic [127:0] TXT_A = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
   localparam logic [127:0] TXT_B = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
   localparam logic [127:0] TXT_C = {32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A};

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   // Push hand-computed beats (addresses, HTRANS codes), data words and completion code
   task automatic exp_burst(input logic [127:0] addrs, input logic [7:0] trans, input logic [2:0] burst,
                            input int n_addr, input logic [127:0] text, input int n_data,
                            input logic [1:0] cmp);
      beat_t b;
      for (int k = 0; k < n_addr; k++) begin
         b.addr  = addrs[k*32 +: 32];
         b.trans = trans[k*2 +: 2];
         b.burst = burst;
         exp_addr_q.push_back(b);
      end
      for (int k = 0; k < n_data; k++) exp_data_q.push_back(text[k*32 +: 32]);
      if (cmp != 2'b00) exp_cmp_q.push_back(cmp);
   endtask

   // Monitor: compares accepted address beats, completed data beats and done/error pulses
   always @(negedge HCLK) begin
      beat_t       eb;
      logic [31:0] ed;
      logic [1:0]  ec;
      if (!HRESETn) begin
         data_pend = 1'b0;
      end else begin
         if (data_pend && bus.HREADY) begin
            if (!bus.HRESP) begin
               if (exp_data_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL sb_data: unexpected HWDATA 0x%0h at %0t", bus.HWDATA, $time);
               end else begin
                  ed = exp_data_q.pop_front();
                  chk("sb_hwdata", 64'(bus.HWDATA), 64'(ed));
               end
            end
            data_pend = 1'b0;
         end
         if (bus.HTRANS != 2'b00 && bus.HREADY) begin
            if (exp_addr_q.size() == 0) begin
               n_chk++;
               $display("FAIL sb_addr: unexpected beat HADDR 0x%0h HTRANS %0d at %0t",
                        bus.HADDR, bus.HTRANS, $time);
            end else begin
               eb = exp_addr_q.pop_front();
               chk("sb_beat", 64'({bus.HADDR, bus.HTRANS, bus.HBURST}),
                   64'({eb.addr, eb.trans, eb.burst}));
               chk("sb_size_write", 64'({bus.HSIZE, bus.HWRITE}), 64'({3'b010, 1'b1}));
            end
            data_pend = 1'b1;
         end
         if (done || error) begin
            if (exp_cmp_q.size() == 0) begin
               n_chk++;
               $display("FAIL sb_cmp: unexpected done=%0b error=%0b at %0t", done, error, $time);
            end else begin
               ec = exp_cmp_q.pop_front();
               chk("sb_completion", 64'({error, done}), 64'(ec));
            end
         end
      end
   end

   // One block transfer: slave stall/error pattern per cycle (bit c = cycle c after text_rcvd)
   task automatic send(input logic [127:0] text, input int upd_cyc, input logic [31:0] upd_dest,
                       input logic [31:0] nrdy, input logic [31:0] resp, input int exp_end,
                       input bit hold_chk, input logic [31:0] hold_addr, input logic [31:0] hold_data);
      int c;
      bit ended;
      encr_text = text;
      text_rcvd = 1'b1;
      if (upd_cyc == 0) begin
         destination  = upd_dest;
         dest_updated = 1'b1;
      end
      ended = 1'b0;
      c = 0;
      while (!ended && c < 30) begin
         tick();
         c++;
         text_rcvd    = 1'b0;
         dest_updated = 1'b0;
         if (c == upd_cyc) begin
            destination  = upd_dest;
            dest_updated = 1'b1;
            text_rcvd    = 1'b1;
            encr_text    = ~text;
         end
         bus.HREADY = !nrdy[c];
         bus.HRESP  = resp[c];
         @(negedge HCLK);
         if (c == 1) begin
            chk("start_busy", 64'(busy), 64'd1);
            chk("start_nonseq", 64'(bus.HTRANS), 64'd2);
         end
         if (hold_chk && nrdy[c]) begin
            chk("stall_haddr", 64'(bus.HADDR), 64'(hold_addr));
            chk("stall_hwdata", 64'(bus.HWDATA), 64'(hold_data));
         end
         if (resp[c] && !nrdy[c]) chk("err_htrans_idle", 64'(bus.HTRANS), 64'd0);
         if (done || error) ended = 1'b1;
      end
      if (!ended) begin
         n_chk++;
         $display("FAIL end_timeout: no done/error within %0d cycles, required cycle %0d", c, exp_end);
      end else begin
         chk("end_cycle", 64'(c), 64'(exp_end));
         chk("end_busy_low", 64'(busy), 64'd0);
      end
      tick();
      bus.HREADY   = 1'b1;
      bus.HRESP    = 1'b0;
      text_rcvd    = 1'b0;
      dest_updated = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      HRESETn      = 1'b0;
      destination  = '0;
      dest_updated = 1'b0;
      encr_text    = '0;
      text_rcvd    = 1'b0;
      bus.HREADY   = 1'b1;
      bus.HRESP    = 1'b0;

      // Reset state
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      chk("rst_bus", 64'({bus.HADDR, bus.HWDATA}), 64'd0);
      chk("rst_ctl", 64'({bus.HTRANS, bus.HBURST, bus.HSIZE, bus.HWRITE, busy, done, error}), 64'd0);
      tick();
      HRESETn = 1'b1;
      tick();

      // Destination write in IDLE, then basic INCR4
      destination  = 32'h0000_1000;
      dest_updated = 1'b1;
      tick();
      dest_updated = 1'b0;
      tick();
      exp_burst({32'h100C, 32'h1008, 32'h1004, 32'h1000}, {2'd3, 2'd3, 2'd3, 2'd2}, 3'b011, 4,
                TXT_A, 4, 2'b01);
      send(TXT_A, -1, 32'h0, 32'h0, 32'h0, 6, 1'b0, 32'h0, 32'h0);
      repeat (2) tick();

      // Two wait states during beat 2's data phase
      exp_burst({32'h100C, 32'h1008, 32'h1004, 32'h1000}, {2'd3, 2'd3, 2'd3, 2'd2}, 3'b011, 4,
                TXT_A, 4, 2'b01);
      send(TXT_A, -1, 32'h0, 32'h30, 32'h0, 8, 1'b1, 32'h100C, 32'hCCCCCCCC);
      repeat (2) tick();

      // Two-cycle ERROR on beat 1: only beats 0,1 addressed, data 0 completes
      exp_burst({32'h0, 32'h0, 32'h1004, 32'h1000}, {2'd0, 2'd0, 2'd3, 2'd2}, 3'b011, 2,
                TXT_B, 1, 2'b10);
      send(TXT_B, -1, 32'h0, 32'h08, 32'h18, 5, 1'b0, 32'h0, 32'h0);
      repeat (3) tick();

      // Pending destination (unaligned 0x2002) plus ignored text_rcvd while busy
      exp_burst({32'h100C, 32'h1008, 32'h1004, 32'h1000}, {2'd3, 2'd3, 2'd3, 2'd2}, 3'b011, 4,
                TXT_B, 4, 2'b01);
      send(TXT_B, 2, 32'h2002, 32'h0, 32'h0, 6, 1'b0, 32'h0, 32'h0);
      repeat (3) tick();
      exp_burst({32'h200C, 32'h2008, 32'h2004, 32'h2000}, {2'd3, 2'd3, 2'd3, 2'd2}, 3'b011, 4,
                TXT_C, 4, 2'b01);
      send(TXT_C, -1, 32'h0, 32'h0, 32'h0, 6, 1'b0, 32'h0, 32'h0);
      repeat (2) tick();

      // 1 KB crossing with destination written in the same cycle as text_rcvd
      exp_burst({32'h404, 32'h400, 32'h3FC, 32'h3F8}, {2'd3, 2'd2, 2'd3, 2'd2}, 3'b001, 4,
                TXT_C, 4, 2'b01);
      send(TXT_C, 0, 32'h3F8, 32'h0, 32'h0, 6, 1'b0, 32'h0, 32'h0);
      repeat (2) tick();

      // Reset mid-burst: beats 0,1 and data 0 seen, then everything discarded
      exp_burst({64'h0, 32'h3FC, 32'h3F8}, {4'd0, 2'd3, 2'd2}, 3'b001, 2, TXT_A, 1, 2'b00);
      encr_text = TXT_A;
      text_rcvd = 1'b1;
      tick();
      text_rcvd = 1'b0;
      tick();
      tick();
      #2;
      HRESETn = 1'b0;
      #1;
      chk("rst_mid_bus", 64'({bus.HADDR, bus.HWDATA}), 64'd0);
      chk("rst_mid_ctl", 64'({bus.HTRANS, bus.HBURST, bus.HSIZE, bus.HWRITE, busy, done, error}), 64'd0);
      repeat (2) tick();
      HRESETn = 1'b1;
      tick();
      @(negedge HCLK);
      chk("post_rst_busy", 64'({busy, bus.HTRANS}), 64'd0);
      chk("post_rst_q_empty", 64'(exp_addr_q.size() + exp_data_q.size() + exp_cmp_q.size()), 64'd0);
      tick();

      // Destination register was reset to 0
      exp_burst({32'h00C, 32'h008, 32'h004, 32'h000}, {2'd3, 2'd3, 2'd3, 2'd2}, 3'b011, 4,
                TXT_B, 4, 2'b01);
      send(TXT_B, -1, 32'h0, 32'h0, 32'h0, 6, 1'b0, 32'h0, 32'h0);
      repeat (4) tick();

      chk("end_addr_q_empty", 64'(exp_addr_q.size()), 64'd0);
      chk("end_data_q_empty", 64'(exp_data_q.size()), 64'd0);
      chk("end_cmp_q_empty", 64'(exp_cmp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
